// File: rtl/lsu_dbus_ctrl_pkg.sv
// ============================================================================
// Module  : lsu_dbus_ctrl_pkg
// Purpose : Shared LSU state encodings, load/store mask codes and trap causes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_dbus_ctrl_pkg;

   typedef enum logic [2:0] {
      LSU_IDLE  = 3'd0,
      LSU_REQ   = 3'd1,
      LSU_WAIT  = 3'd2,
      LSU_DONE  = 3'd3,
      LSU_DRAIN = 3'd4
   } lsu_state_t;

   // bit4 = sign-extend, bits[3:0] = access size
   localparam logic [4:0] LMASK_B  = 5'b10001;
   localparam logic [4:0] LMASK_H  = 5'b10011;
   localparam logic [4:0] LMASK_W  = 5'b11111;
   localparam logic [4:0] LMASK_BU = 5'b00001;
   localparam logic [4:0] LMASK_HU = 5'b00011;

   localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
   localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
   localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

   // Any encoding other than byte or half is handled as a full word.
   function automatic logic [3:0] lsu_size(input logic [3:0] m);
      if (m == LMASK_BU[3:0])
         return 4'b0001;
      else if (m == LMASK_HU[3:0])
         return 4'b0011;
      else
         return 4'b1111;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_store_align.sv
// ============================================================================
// Module  : lsu_store_align
// Purpose : Byte-enable generation, store lane replication, misalign detect.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_store_align
   import lsu_dbus_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      addr_low,
   input  logic [3:0]      size_mask,
   input  logic [XLEN-1:0] store_data,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic            misaligned
);

   logic [3:0] size;

   always_comb begin
      size       = lsu_size(size_mask);
      be         = size << addr_low;
      wdata      = store_data;
      misaligned = 1'b0;
      case (size)
         4'b0001: wdata = {(XLEN/8){store_data[7:0]}};
         4'b0011: begin
            wdata      = {(XLEN/16){store_data[15:0]}};
            misaligned = addr_low[0];
         end
         default: misaligned = (addr_low != 2'b00);
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu_dbus_ctrl.sv
// ============================================================================
// Module  : lsu_dbus_ctrl
// Purpose : EX->MEM load/store controller driving a req/gnt/rvalid data bus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_dbus_ctrl
   import lsu_dbus_ctrl_pkg::*;
#(
   parameter int XLEN             = 32,
   parameter bit DISCARD_ON_FLUSH = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic            ex_is_load,
   input  logic            ex_is_store,
   input  logic [XLEN-1:0] ex_ls_addr,
   input  logic [XLEN-1:0] ex_store_data,
   input  logic [4:0]      ex_ls_mask,
   input  logic            flush,
   input  logic            mem_ready,
   output logic            lsu_stall,
   output logic            dbus_req,
   output logic            dbus_we,
   output logic [XLEN-1:0] dbus_addr,
   output logic [3:0]      dbus_be,
   output logic [XLEN-1:0] dbus_wdata,
   input  logic            dbus_gnt,
   input  logic            dbus_rvalid,
   input  logic [XLEN-1:0] dbus_rdata,
   input  logic            dbus_err,
   output logic            lsu_res_valid,
   output logic [XLEN-1:0] mem_load_data_o,
   output logic [1:0]      mem_ls_addr_2low_o,
   output logic [4:0]      mem_l_mask_o,
   output logic            lsu_exp_flag,
   output logic [3:0]      lsu_exp_cause,
   output logic [XLEN-1:0] lsu_bad_addr
);

   lsu_state_t      state, state_nxt;
   logic            ls_op, misaligned, kill, accept, rsp_take, flush_pend;
   logic [3:0]      be_c;
   logic [XLEN-1:0] wdata_c;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q, bad_addr_q;
   logic [3:0]      be_q, cause_q;
   logic [4:0]      mask_q;
   logic            we_q, exp_q;

   assign ls_op = ex_valid && (ex_is_load || ex_is_store);
   // A granted request cannot be withdrawn, so a flush only decides whether
   // the eventual response is dropped.
   assign kill     = DISCARD_ON_FLUSH && flush;
   assign accept   = (state == LSU_IDLE) && ls_op && !flush;
   assign rsp_take = (state == LSU_WAIT) && dbus_rvalid && !kill;

   lsu_store_align #(.XLEN(XLEN)) u_align (
      .addr_low   (ex_ls_addr[1:0]),
      .size_mask  (ex_ls_mask[3:0]),
      .store_data (ex_store_data),
      .be         (be_c),
      .wdata      (wdata_c),
      .misaligned (misaligned)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= LSU_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      dbus_req      = 1'b0;
      lsu_res_valid = 1'b0;
      lsu_stall     = ls_op;
      case (state)
         LSU_IDLE: begin
            if (accept)
               state_nxt = misaligned ? LSU_DONE : LSU_REQ;
         end
         LSU_REQ: begin
            dbus_req  = 1'b1;
            lsu_stall = 1'b1;
            if (dbus_gnt)
               state_nxt = (kill || flush_pend) ? LSU_DRAIN : LSU_WAIT;
         end
         LSU_WAIT: begin
            lsu_stall = 1'b1;
            if (kill)
               state_nxt = dbus_rvalid ? LSU_IDLE : LSU_DRAIN;
            else if (dbus_rvalid)
               state_nxt = LSU_DONE;
         end
         LSU_DONE: begin
            lsu_res_valid = !flush;
            lsu_stall     = ls_op && !mem_ready;
            if (flush || mem_ready)
               state_nxt = LSU_IDLE;
         end
         LSU_DRAIN: begin
            lsu_stall = 1'b1;
            if (dbus_rvalid)
               state_nxt = LSU_IDLE;
         end
         default: state_nxt = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         bad_addr_q <= '0;
         be_q       <= '0;
         cause_q    <= '0;
         mask_q     <= '0;
         we_q       <= 1'b0;
         exp_q      <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         flush_pend <= (state == LSU_REQ && !dbus_gnt) ? (flush_pend || kill) : 1'b0;
         if (accept) begin
            addr_q     <= ex_ls_addr;
            mask_q     <= ex_ls_mask;
            rdata_q    <= '0;
            we_q       <= ex_is_store && !misaligned;
            be_q       <= misaligned ? 4'b0000 : be_c;
            wdata_q    <= (ex_is_store && !misaligned) ? wdata_c : '0;
            exp_q      <= misaligned;
            cause_q    <= !misaligned ? 4'd0 :
                          ex_is_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
            bad_addr_q <= misaligned ? ex_ls_addr : '0;
         end else if (rsp_take) begin
            if (!we_q)
               rdata_q <= dbus_rdata;
            if (dbus_err) begin
               exp_q      <= 1'b1;
               cause_q    <= we_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
               bad_addr_q <= addr_q;
            end
         end
      end
   end

   assign dbus_we            = we_q;
   assign dbus_addr          = {addr_q[XLEN-1:2], 2'b00};
   assign dbus_be            = be_q;
   assign dbus_wdata         = wdata_q;
   assign mem_load_data_o    = rdata_q;
   assign mem_ls_addr_2low_o = addr_q[1:0];
   assign mem_l_mask_o       = mask_q;
   assign lsu_exp_flag       = exp_q;
   assign lsu_exp_cause      = cause_q;
   assign lsu_bad_addr       = bad_addr_q;

endmodule

`default_nettype wire
